// File: rtl/scorpion_actuator.sv
// Scorpion action-bus receiver: 2-FF sync, stability filter, code decode and
// a timed actuator FSM driving the leg-reverse motor, claw and sting.
module scorpion_actuator #(
  parameter int STABLE_CYCLES = 4,
  parameter int PULSE_LEN     = 8,
  parameter int STING_LEN     = 4,
  parameter int COOLDOWN      = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] pio_in_i,
  output logic [1:0] action_o,
  output logic       err_o,
  output logic       motor_back_o,
  output logic       claw_o,
  output logic       sting_o,
  output logic       busy_o
);

  localparam int TMAX01 = (PULSE_LEN > STING_LEN) ? PULSE_LEN : STING_LEN;
  localparam int TMAX   = (TMAX01 > COOLDOWN) ? TMAX01 : COOLDOWN;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int CW     = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] A_WAIT = 2'b00;
  localparam logic [1:0] A_RET  = 2'b01;
  localparam logic [1:0] A_ATK  = 2'b10;
  localparam logic [1:0] A_DART = 2'b11;

  typedef enum logic [2:0] {
    IDLE, RETREAT, CLAW_ON, CLAW_OFF, STING, COOL, DART_HOLD
  } state_e;

  logic [3:0]    sync1_q, s_q, cand_q, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept, legal;
  logic [1:0]    dec;

  // cnt saturates at STABLE_CYCLES, so the accept fires only on the edge it gets there
  always_comb begin
    if (s_q != cand_q)                       cnt_d = CW'(1);
    else if (cnt_q == CW'(STABLE_CYCLES))    cnt_d = cnt_q;
    else                                     cnt_d = cnt_q + CW'(1);
    accept = (cnt_d == CW'(STABLE_CYCLES)) &&
             ((cnt_q != CW'(STABLE_CYCLES)) || (s_q != cand_q));
  end

  always_comb begin
    legal = 1'b1;
    dec   = A_WAIT;
    case (s_q)
      4'b0000: dec = A_WAIT;
      4'b1000: dec = A_RET;
      4'b0101: dec = A_ATK;
      4'b0010: dec = A_DART;
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= '0;
      s_q      <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      action_o <= A_WAIT;
      err_o    <= 1'b0;
    end else begin
      sync1_q <= pio_in_i;
      s_q     <= sync1_q;
      cand_q  <= s_q;
      cnt_q   <= cnt_d;
      err_o   <= accept && !legal && (s_q != last_q);
      if (accept) begin
        last_q <= s_q;
        if (legal) action_o <= dec;
      end
    end
  end

  state_e        state_q, state_d;
  logic [TW-1:0] tmr_q;

  function automatic state_e follow(input logic [1:0] a);
    case (a)
      A_RET:   return RETREAT;
      A_ATK:   return CLAW_ON;
      A_DART:  return STING;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [TW-1:0] load(input state_e st);
    case (st)
      CLAW_ON, CLAW_OFF: return TW'(PULSE_LEN - 1);
      STING:             return TW'(STING_LEN - 1);
      COOL:              return TW'(COOLDOWN - 1);
      default:           return '0;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    if (action_o == A_RET) state_d = RETREAT;
    else begin
      case (state_q)
        IDLE, RETREAT: state_d = follow(action_o);
        CLAW_ON:   if (action_o != A_ATK) state_d = follow(action_o);
                   else if (tmr_q == '0)  state_d = CLAW_OFF;
        CLAW_OFF:  if (action_o != A_ATK) state_d = follow(action_o);
                   else if (tmr_q == '0)  state_d = CLAW_ON;
        STING:     if (tmr_q == '0) state_d = COOL;
        // after cooldown a held dart parks instead of firing again
        COOL:      if (tmr_q == '0)
                     state_d = (action_o == A_DART) ? DART_HOLD : follow(action_o);
        DART_HOLD: if (action_o != A_DART) state_d = follow(action_o);
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      tmr_q        <= '0;
      motor_back_o <= 1'b0;
      claw_o       <= 1'b0;
      sting_o      <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      if (state_d != state_q) tmr_q <= load(state_d);
      else if (tmr_q != '0)   tmr_q <= tmr_q - TW'(1);
      motor_back_o <= (state_d == RETREAT);
      claw_o       <= (state_d == CLAW_ON);
      sting_o      <= (state_d == STING);
      busy_o       <= (state_d != IDLE);
    end
  end

endmodule

// File: doc/scorpion_actuator.md
Name: scorpion_actuator

Overview:
- Receiving end of the 4-line scorpion action bus (PIO bits 76..79) on the actuator board.
- Synchronises and glitch-filters the incoming action code, then decodes it into wait / retreat / attack / dart.
- Drives timed actuator outputs: a continuous leg-reverse motor, a pulsed claw and a single-shot sting with cooldown.
- Flags illegal bus codes.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronised samples of an identical code required before it is accepted (>=1).
- PULSE_LEN, 8: claw on-time and off-time in clocks (>=1).
- STING_LEN, 4: sting pulse width in clocks (>=1).
- COOLDOWN, 16: sting lockout after each pulse, in clocks (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- pio_in  in  4  asynchronous action bus; bit3=PIO76, bit2=PIO77, bit1=PIO78, bit0=PIO79.
- action  out  2  accepted action: 00 wait, 01 retreat, 10 attack, 11 dart.
- err  out  1  one-cycle pulse when an illegal code is accepted.
- motor_back  out  1  leg-reverse motor enable.
- claw  out  1  claw actuator, pulsed.
- sting  out  1  sting actuator, single pulse.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: sync registers, candidate and counter cleared; action=00; err, motor_back, claw, sting and busy all 0; FSM goes to IDLE. Reset takes effect mid-pulse or mid-cooldown with no residual output on the next cycle.
- Synchroniser: 2-FF chain on pio_in; s is the second-stage output.
- Filter:
  - Candidate register cand and counter cnt (saturating at STABLE_CYCLES).
  - If s != cand: cand<=s, cnt<=1. Otherwise cnt increments.
  - The code is accepted on the edge where cnt reaches STABLE_CYCLES.
  - Any glitch shorter than STABLE_CYCLES synchronised samples never reaches action.
  - Latency: with pio_in stable from sampling edge 1, action updates on edge STABLE_CYCLES+2 (edge 6 at default).
- Decode on accept: 0000 gives wait, 1000 retreat, 0101 attack, 0010 dart.
  - Any other code pulses err for exactly one cycle on the acceptance edge; action holds its previous value.
  - Re-acceptance of the same code does not re-pulse err. err pulses again only after a different code is accepted first.
- FSM states: IDLE, RETREAT, CLAW_ON, CLAW_OFF, STING, COOL, DART_HOLD. Transitions are evaluated on the edge after action changes.
  - From any state, action=retreat goes to RETREAT. Retreat pre-empts everything, including an active STING and COOL (cooldown abandoned). motor_back=1 only in RETREAT.
  - RETREAT: action=wait goes to IDLE; attack goes to CLAW_ON; dart goes to STING.
  - IDLE: attack goes to CLAW_ON; dart goes to STING.
  - CLAW_ON: claw=1 for PULSE_LEN cycles, then CLAW_OFF.
  - CLAW_OFF: claw=0 for PULSE_LEN cycles, then CLAW_ON if action is still attack.
  - If action leaves attack while in CLAW_ON/CLAW_OFF: claw drops to 0 on the next edge, and the FSM goes to the state matching the new action (wait gives IDLE, dart gives STING).
  - STING: sting=1 for exactly STING_LEN cycles (non-retreat action changes do not truncate it), then COOL.
  - COOL: all outputs 0 for COOLDOWN cycles. Then DART_HOLD if action=dart, IDLE if wait, CLAW_ON if attack.
  - DART_HOLD: no output. Stays until action != dart. A new sting requires action to leave dart and be re-accepted as dart.
- Timer: one shared down-counter sized for max(PULSE_LEN, STING_LEN, COOLDOWN); it reloads on every state entry.

Test Plan:
- Reset, then pio_in=1000 held -> action=01 at edge 6; motor_back=1 from the next edge; busy=1. Then pio_in=0000 -> motor_back=0, action=00, busy=0.
- pio_in=0101 held 40 cycles -> claw toggles 8 high / 8 low repeatedly. Switch to 0000 mid-CLAW_ON -> claw=0 on the edge after action changes.
- pio_in=0010 held -> sting high exactly 4 cycles, then 16 cycles of 0, then DART_HOLD with no second pulse. Then 0000, then 0010 again -> a second 4-cycle pulse.
- Glitch: pio_in=1000 for 3 cycles, then 0000 -> action stays 00, motor_back never asserts, err=0.
- Illegal: pio_in=1111 held 10 cycles -> err high exactly one cycle, action unchanged; held further -> no further err pulses.
- Pre-emption and reset: dart, then retreat during the 2nd sting cycle -> sting=0 and motor_back=1 on the edge after action=01. Assert reset during CLAW_ON -> all outputs 0 next cycle, action=00.
